// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 32-bit arithmetic right shifter.
// Results are queued with the issuing requester index in a FIFO_DEPTH-entry FIFO.
// FIFO_DEPTH must be a power of two in 2..16, so the pointers wrap on their own.
// Optional feature macro: SHIFT_ARB_ROUND_ROBIN_EN
//   defined   -> on contention, the requester not served last wins
//   undefined -> on contention, requester 0 always wins (no pointer state)
module shift_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_amt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_amt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_id
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   data_mem_q [FIFO_DEPTH];
    logic [31:0]   data_mem_d [FIFO_DEPTH];
    logic          id_mem_q   [FIFO_DEPTH];
    logic          id_mem_d   [FIFO_DEPTH];

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    logic last_id_q, last_id_d;
`endif

    logic        gnt_id;
    logic        not_full;
    logic        push;
    logic        pop;
    logic        push_id;
    logic [31:0] push_data;
    logic [4:0]  push_amt;
    logic [31:0] shift_res;

    // Grant selection: a lone requester always wins; contention follows the policy.
    always_comb begin
        gnt_id = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
            gnt_id = ~last_id_q;
`else
            gnt_id = 1'b0;
`endif
        end else if (req1_valid) begin
            gnt_id = 1'b1;
        end
    end

    // Readies depend only on valids, grant and count; a full FIFO blocks even if popping.
    always_comb begin
        not_full   = (count_q < CW'(FIFO_DEPTH));
        req0_ready = !reset && req0_valid && !gnt_id && not_full;
        req1_ready = !reset && req1_valid &&  gnt_id && not_full;
    end

    // Shared datapath: mux the accepted operand and shift it arithmetically.
    always_comb begin
        push      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        push_id   = req1_valid && req1_ready;
        push_data = push_id ? req1_data : req0_data;
        push_amt  = push_id ? req1_amt  : req0_amt;
        shift_res = $signed(push_data) >>> push_amt;
        pop       = (count_q != '0) && out_ready;
    end

    // Next-state for FIFO bookkeeping and storage.
    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        data_mem_d = data_mem_q;
        id_mem_d   = id_mem_q;
        if (push) begin
            data_mem_d[wr_ptr_q] = shift_res;
            id_mem_d[wr_ptr_q]   = push_id;
        end
    end

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    // Remember who was served last; only an accepted transfer moves it.
    always_comb begin
        last_id_d = push ? push_id : last_id_q;
    end

    // Reset value 1 makes requester 0 win the first contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_id_q <= 1'b1;
        end else begin
            last_id_q <= last_id_d;
        end
    end
`endif

    // FIFO control registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; stale entries are never visible because out_data is masked.
    always_ff @(posedge clock) begin
        data_mem_q <= data_mem_d;
        id_mem_q   <= id_mem_d;
    end

    // Head presentation, forced to zero when the FIFO is empty.
    always_comb begin
        out_valid = (count_q != '0);
        out_data  = out_valid ? data_mem_q[rd_ptr_q] : 32'h0;
        out_id    = out_valid ? id_mem_q[rd_ptr_q]   : 1'b0;
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter. Stimulus drives directed vectors with
// hand-computed results; a negedge monitor predicts readies/acceptance from a
// small handshake model, queues expected results and checks them on each pop.
// Honors SHIFT_ARB_ROUND_ROBIN_EN for the contention policy.
module tb_shift_arbiter;

    localparam int DEPTH = 2;

    logic        clock;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_data;
    logic [4:0]  req0_amt;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_data;
    logic [4:0]  req1_amt;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_id;

    shift_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] pend0, pend1;
    logic        m_last;
    logic        m_gnt, m_r0, m_r1, m_pop;
    exp_t        m_head;

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set0(input logic v, input logic [31:0] d, input logic [4:0] a, input logic [31:0] e);
        req0_valid = v; req0_data = d; req0_amt = a; pend0 = e;
    endtask

    task automatic set1(input logic v, input logic [31:0] d, input logic [4:0] a, input logic [31:0] e);
        req1_valid = v; req1_data = d; req1_amt = a; pend1 = e;
    endtask

    // Monitor: predict handshake from the model, compare, then advance the model.
    always @(negedge clock) begin
        if (reset) begin
            check("rst_ready0", {31'b0, req0_ready}, 32'd0);
            check("rst_ready1", {31'b0, req1_ready}, 32'd0);
            sb_q.delete();
            m_last = 1'b1;
        end else begin
            m_gnt = 1'b0;
            if (req0_valid && req1_valid) m_gnt = RR ? ~m_last : 1'b0;
            else if (req1_valid)          m_gnt = 1'b1;
            m_r0  = req0_valid && !m_gnt && (sb_q.size() < DEPTH);
            m_r1  = req1_valid &&  m_gnt && (sb_q.size() < DEPTH);
            m_pop = (sb_q.size() != 0) && out_ready;
            check("req0_ready", {31'b0, req0_ready}, {31'b0, m_r0});
            check("req1_ready", {31'b0, req1_ready}, {31'b0, m_r1});
            check("out_valid",  {31'b0, out_valid},  {31'b0, (sb_q.size() != 0)});
            if (sb_q.size() == 0) begin
                check("empty_data", out_data, 32'd0);
                check("empty_id",   {31'b0, out_id}, 32'd0);
            end
            if (m_pop) begin
                m_head = sb_q.pop_front();
                check("out_data", out_data, m_head.data);
                check("out_id",   {31'b0, out_id}, {31'b0, m_head.id});
            end
            if (m_r0) begin
                sb_q.push_back('{id: 1'b0, data: pend0});
                m_last = 1'b0;
            end
            if (m_r1) begin
                sb_q.push_back('{id: 1'b1, data: pend1});
                m_last = 1'b1;
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b1;
        out_ready = 1'b0;
        set0(1'b0, 32'h0, 5'd0, 32'h0);
        set1(1'b0, 32'h0, 5'd0, 32'h0);
        tick(2);
        reset = 1'b0;
        tick(2);

        // Basic sign-extending shift on requester 0
        out_ready = 1'b1;
        set0(1'b1, 32'h8000_0000, 5'd4, 32'hF800_0000);
        tick(1);
        set0(1'b0, 32'h0, 5'd0, 32'h0);
        tick(2);

        // Boundary amounts on requester 1
        set1(1'b1, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000);
        tick(1);
        set1(1'b1, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF);
        tick(1);
        set1(1'b1, 32'h1234_5678, 5'd0, 32'h1234_5678);
        tick(1);
        set1(1'b0, 32'h0, 5'd0, 32'h0);
        tick(2);

        // Continuous contention: 0,1,0,1 with round robin, else 0,0,0,0
        set0(1'b1, 32'h0000_0100, 5'd4, 32'h0000_0010);
        set1(1'b1, 32'hF000_0000, 5'd8, 32'hFFF0_0000);
        tick(4);
        set0(1'b0, 32'h0, 5'd0, 32'h0);
        set1(1'b0, 32'h0, 5'd0, 32'h0);
        tick(3);

        // Fill to full with consumer stalled, then drain in order and resume
        out_ready = 1'b0;
        set0(1'b1, 32'h0000_0010, 5'd1, 32'h0000_0008);
        tick(1);
        set0(1'b1, 32'hC000_0000, 5'd2, 32'hF000_0000);
        tick(1);
        set0(1'b1, 32'h0000_0001, 5'd0, 32'h0000_0001);
        tick(2);
        out_ready = 1'b1;
        tick(2);
        set0(1'b0, 32'h0, 5'd0, 32'h0);
        tick(3);

        // Reset with two results buffered: they must never appear
        out_ready = 1'b0;
        set0(1'b1, 32'h0000_0004, 5'd2, 32'h0000_0001);
        tick(2);
        set0(1'b0, 32'h0, 5'd0, 32'h0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        out_ready = 1'b1;
        set0(1'b1, 32'h4000_0000, 5'd30, 32'h0000_0001);
        set1(1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        tick(2);
        set0(1'b0, 32'h0, 5'd0, 32'h0);
        set1(1'b0, 32'h0, 5'd0, 32'h0);

        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            tick(1);
            waited++;
        end
        tick(1);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
